// File: rtl/core_pkg.sv
// Shared core constants and the fetch sequencer state encoding.
package core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    typedef enum logic [1:0] {
        BOOT = ST_BOOT,
        RUN  = ST_RUN,
        HALT = ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO between the fetch stage and decode; flush empties it in one cycle.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // On a full queue with push+pop the write lands in the slot being vacated.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, fetches from combinational instruction memory and queues {pc,instr} for decode.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256,
    parameter int unsigned FQ_DEPTH   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_en,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic [XLEN-1:0]             imem_pc,
    input  logic [INSTR_W-1:0]          imem_instr,
    output logic                        if_valid,
    output logic [XLEN-1:0]             if_pc,
    output logic [INSTR_W-1:0]          if_instr,
    input  logic                        id_ready,
    output logic [$clog2(FQ_DEPTH):0]   fq_count,
    output logic                        fetch_err
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned ENT_W = XLEN + INSTR_W;

    fetch_state_t      r_state;
    logic [XLEN-1:0]   r_pc;
    logic              r_err;

    logic              w_redirect;
    logic              w_pop;
    logic              w_attempt;
    logic              w_bad_pc;
    logic              w_push;
    logic              w_err_set;
    logic [ENT_W-1:0]  w_head;

    // Redirect is ignored in BOOT and suppresses push/pop in the same cycle.
    assign w_redirect = redirect_valid && (r_state != BOOT);
    assign w_pop      = if_valid && id_ready && !w_redirect;
    assign w_attempt  = (r_state == RUN) && fetch_en && !w_redirect &&
                        ((fq_count < CNT_W'(FQ_DEPTH)) || w_pop);
    assign w_bad_pc   = (r_pc[1:0] != 2'b00) || (r_pc >= XLEN'(IMEM_BYTES));
    assign w_push     = w_attempt && !w_bad_pc;
    assign w_err_set  = w_attempt && w_bad_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_err   <= 1'b0;
        end else begin
            if (w_redirect)  r_pc <= redirect_pc;
            else if (w_push) r_pc <= r_pc + XLEN'(4);
            if (w_err_set) r_err <= 1'b1;
            unique case (r_state)
                BOOT:    r_state <= RUN;
                RUN:     if (!fetch_en || w_err_set) r_state <= HALT;
                HALT:    if (fetch_en && !r_err && !w_redirect) r_state <= RUN;
                default: r_state <= BOOT;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (ENT_W)
    ) u_fetch_queue (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_data  ({r_pc, imem_instr}),
        .o_valid (if_valid),
        .o_data  (w_head),
        .o_count (fq_count)
    );

    assign imem_pc   = r_pc;
    assign if_pc     = w_head[ENT_W-1:INSTR_W];
    assign if_instr  = w_head[INSTR_W-1:0];
    assign fetch_err = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed check of fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned MEMB  = 256;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;
    logic [1:0]  fq_count;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    // Reference model: booted/running flags, pc, sticky error and a plain queue of entries.
    bit          m_booted;
    bit          m_run;
    bit          m_err;
    logic [31:0] m_pc;
    logic [63:0] mq[$];

    fetch_sequencer #(
        .RESET_PC   (32'h0),
        .IMEM_BYTES (MEMB),
        .FQ_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready),
        .fq_count       (fq_count),
        .fetch_err      (fetch_err)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    assign imem_instr = word(imem_pc);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_booted = 1'b0;
        m_run    = 1'b0;
        m_err    = 1'b0;
        m_pc     = 32'h0;
        mq.delete();
    endtask

    task automatic model_step();
        bit pop;
        bit attempt;
        bit bad;
        if (!rst_n) begin
            model_reset();
        end else if (!m_booted) begin
            m_booted = 1'b1;
            m_run    = 1'b1;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc;
            if (m_run && !fetch_en) m_run = 1'b0;
        end else begin
            pop     = (mq.size() > 0) && id_ready;
            attempt = m_run && fetch_en && ((mq.size() < DEPTH) || pop);
            bad     = (m_pc % 4 != 0) || (m_pc >= MEMB);
            if (pop) void'(mq.pop_front());
            if (attempt && !bad) begin
                mq.push_back({m_pc, word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            if (attempt && bad) begin
                m_err = 1'b1;
                m_run = 1'b0;
            end else if (m_run && !fetch_en) begin
                m_run = 1'b0;
            end else if (!m_run && fetch_en && !m_err) begin
                m_run = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        logic [31:0] e_pc;
        logic [31:0] e_in;
        forever begin
            @(negedge clk);
            e_pc = (mq.size() > 0) ? mq[0][63:32] : 32'h0;
            e_in = (mq.size() > 0) ? mq[0][31:0] : 32'h0;
            check("imem_pc", imem_pc, m_pc);
            check("if_valid", 32'(if_valid), 32'(mq.size() > 0));
            check("if_pc", if_pc, e_pc);
            check("if_instr", if_instr, e_in);
            check("fq_count", 32'(fq_count), 32'(mq.size()));
            check("fetch_err", 32'(fetch_err), 32'(m_err));
        end
    end

    initial begin
        logic [31:0] got[$];
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        rst_n          = 1'b0;
        model_reset();
        tick();
        check("reset_if_valid", 32'(if_valid), 32'h0);
        check("reset_imem_pc", imem_pc, 32'h0);
        check("reset_fetch_err", 32'(fetch_err), 32'h0);
        tick();
        rst_n = 1'b1;

        // Streaming from reset: one instruction per cycle from cycle 2.
        tick();
        check("boot_no_valid", 32'(if_valid), 32'h0);
        tick();
        check("stream_pc0", if_pc, 32'h0);
        check("stream_instr0", if_instr, word(32'h0));
        tick();
        check("stream_pc4", if_pc, 32'h4);
        tick();
        check("stream_pc8", if_pc, 32'h8);
        check("model_pc_c", m_pc, 32'hC);

        // Back-pressure from reset saturates the queue.
        id_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        check("bp_count", 32'(fq_count), 32'd2);
        check("bp_pc_frozen", imem_pc, 32'h8);
        check("bp_head_pc", if_pc, 32'h0);
        check("model_size", 32'(mq.size()), 32'd2);

        // Redirect while full, ready high: head not consumed, queue flushed.
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush", 32'(fq_count), 32'd0);
        check("redir_pc", imem_pc, 32'h40);
        tick();
        check("redir_target", if_pc, 32'h40);
        check("redir_valid", 32'(if_valid), 32'h1);

        // Misaligned redirect halts with a sticky error.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("misalign_err", 32'(fetch_err), 32'h1);
        check("misalign_novalid", 32'(if_valid), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        check("halt_redir_pc", imem_pc, 32'h80);
        repeat (3) tick();
        check("halt_stays", 32'(if_valid), 32'h0);
        check("err_sticky", 32'(fetch_err), 32'h1);

        // Running off the end of memory: queued tail still drains.
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hF0;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (if_valid) got.push_back(if_pc);
            tick();
        end
        check("end_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("end_f8", got[2], 32'hF8);
            check("end_fc", got[3], 32'hFC);
        end
        check("end_err", 32'(fetch_err), 32'h1);

        // fetch_en stall, then reset mid-stream.
        do_reset();
        repeat (4) tick();
        fetch_en = 1'b0;
        repeat (3) tick();
        fetch_en = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_valid", 32'(if_valid), 32'h0);
        check("mid_rst_pc", imem_pc, 32'h0);
        check("mid_rst_count", 32'(fq_count), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("restart_pc0", if_pc, 32'h0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end
            id_ready       = ($urandom_range(0, 3) != 0);
            fetch_en       = ($urandom_range(0, 9) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) != 0) redirect_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            else redirect_pc = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
